// File: rtl/trace_fifo_sequencer.sv
// Trace FIFO sequencer: reads sniffed trace entries one at a time, folds TIME
// entries into a timestamp accumulator and emits reassembled match events.
module trace_fifo_sequencer #(
    parameter int pDATA_W = 32,
    parameter int pRULE_W = 8,
    parameter int pCNT_W  = 16
) (
    input  logic               trace_clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               flush,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    input  logic [pDATA_W-1:0] fifo_dout,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [pRULE_W-1:0] ev_rule,
    output logic [pDATA_W-1:0] ev_time,
    output logic               ev_long,
    output logic [pCNT_W-1:0]  event_count,
    output logic [pCNT_W-1:0]  stat_count,
    output logic               err_bad_cmd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_OUT
    } state_t;

    state_t               state_q, state_d;
    logic [pDATA_W-1:0]   time_acc_q, time_acc_d;
    logic                 long_seen_q, long_seen_d;
    logic                 ev_valid_q, ev_valid_d;
    logic [pRULE_W-1:0]   ev_rule_q, ev_rule_d;
    logic [pDATA_W-1:0]   ev_time_q, ev_time_d;
    logic                 ev_long_q, ev_long_d;
    logic [pCNT_W-1:0]    event_count_q, event_count_d;
    logic [pCNT_W-1:0]    stat_count_q, stat_count_d;
    logic                 err_bad_cmd_q, err_bad_cmd_d;

    logic [1:0]           cmd;
    logic [pRULE_W-1:0]   rule;
    logic [pDATA_W-1:0]   short_time;
    logic [pDATA_W-1:0]   full_time;

    assign cmd        = fifo_dout[1:0];
    assign rule       = fifo_dout[8 +: pRULE_W];
    assign short_time = {{(pDATA_W-6){1'b0}}, fifo_dout[7:2]};
    assign full_time  = {2'b00, fifo_dout[pDATA_W-1:2]};

    always_comb begin
        state_d       = state_q;
        time_acc_d    = time_acc_q;
        long_seen_d   = long_seen_q;
        ev_valid_d    = ev_valid_q;
        ev_rule_d     = ev_rule_q;
        ev_time_d     = ev_time_q;
        ev_long_d     = ev_long_q;
        event_count_d = event_count_q;
        stat_count_d  = stat_count_q;
        err_bad_cmd_d = err_bad_cmd_q;
        fifo_rd       = 1'b0;

        // Flush wins over everything, including the decode of an entry in WAIT.
        if (flush) begin
            state_d     = S_IDLE;
            ev_valid_d  = 1'b0;
            time_acc_d  = '0;
            long_seen_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && !fifo_empty) begin
                        fifo_rd = 1'b1;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    state_d = S_IDLE;
                    case (cmd)
                        2'b00: begin
                            ev_time_d   = time_acc_q + short_time;
                            ev_rule_d   = rule;
                            ev_long_d   = long_seen_q;
                            ev_valid_d  = 1'b1;
                            time_acc_d  = '0;
                            long_seen_d = 1'b0;
                            state_d     = S_OUT;
                        end
                        2'b01: begin
                            time_acc_d  = full_time;
                            long_seen_d = 1'b1;
                        end
                        2'b10: begin
                            if (stat_count_q != '1) stat_count_d = stat_count_q + 1'b1;
                        end
                        default: err_bad_cmd_d = 1'b1;
                    endcase
                end
                S_OUT: begin
                    if (ev_ready) begin
                        ev_valid_d = 1'b0;
                        state_d    = S_IDLE;
                        if (event_count_q != '1) event_count_d = event_count_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge trace_clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            time_acc_q    <= '0;
            long_seen_q   <= 1'b0;
            ev_valid_q    <= 1'b0;
            ev_rule_q     <= '0;
            ev_time_q     <= '0;
            ev_long_q     <= 1'b0;
            event_count_q <= '0;
            stat_count_q  <= '0;
            err_bad_cmd_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            time_acc_q    <= time_acc_d;
            long_seen_q   <= long_seen_d;
            ev_valid_q    <= ev_valid_d;
            ev_rule_q     <= ev_rule_d;
            ev_time_q     <= ev_time_d;
            ev_long_q     <= ev_long_d;
            event_count_q <= event_count_d;
            stat_count_q  <= stat_count_d;
            err_bad_cmd_q <= err_bad_cmd_d;
        end
    end

    assign ev_valid    = ev_valid_q;
    assign ev_rule     = ev_rule_q;
    assign ev_time     = ev_time_q;
    assign ev_long     = ev_long_q;
    assign event_count = event_count_q;
    assign stat_count  = stat_count_q;
    assign err_bad_cmd = err_bad_cmd_q;

endmodule

// File: tb/tb_trace_fifo_sequencer.sv
// Directed bench for trace_fifo_sequencer with a small behavioural sniff FIFO
// whose read data appears one cycle after the read strobe.
module tb_trace_fifo_sequencer;

    logic        trace_clk;
    logic        resetn;
    logic        enable;
    logic        flush;
    logic        fifo_empty;
    logic        fifo_rd;
    logic [31:0] fifo_dout;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_rule;
    logic [31:0] ev_time;
    logic        ev_long;
    logic [15:0] event_count;
    logic [15:0] stat_count;
    logic        err_bad_cmd;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] fifo_q[$];

    trace_fifo_sequencer #(
        .pDATA_W(32),
        .pRULE_W(8),
        .pCNT_W (16)
    ) dut (
        .trace_clk  (trace_clk),
        .resetn     (resetn),
        .enable     (enable),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_rule    (ev_rule),
        .ev_time    (ev_time),
        .ev_long    (ev_long),
        .event_count(event_count),
        .stat_count (stat_count),
        .err_bad_cmd(err_bad_cmd)
    );

    initial trace_clk = 1'b0;
    always #5 trace_clk = ~trace_clk;

    // FIFO model: strobe sampled mid low-phase, data presented just after the edge.
    initial begin
        logic rd;
        forever begin
            @(negedge trace_clk);
            #3;
            rd = fifo_rd;
            @(posedge trace_clk);
            #1;
            if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge trace_clk);
    endtask

    task automatic push(input logic [31:0] word);
        fifo_q.push_back(word);
        fifo_empty = 1'b0;
    endtask

    task automatic expect_event(input string tag, input logic [7:0] r,
                                input logic [31:0] t, input logic l);
        int unsigned n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!ev_valid && n < 20);
        check({tag, "_valid"}, {31'b0, ev_valid}, 32'd1);
        check({tag, "_rule"},  {24'b0, ev_rule},  {24'b0, r});
        check({tag, "_time"},  ev_time, t);
        check({tag, "_long"},  {31'b0, ev_long},  {31'b0, l});
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        resetn     = 1'b0;
        enable     = 1'b0;
        flush      = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        ev_ready   = 1'b0;

        cyc();
        check("rst_rd",    {31'b0, fifo_rd},     32'd0);
        check("rst_valid", {31'b0, ev_valid},    32'd0);
        check("rst_time",  ev_time,              32'd0);
        check("rst_evcnt", {16'b0, event_count}, 32'd0);
        check("rst_stcnt", {16'b0, stat_count},  32'd0);
        check("rst_err",   {31'b0, err_bad_cmd}, 32'd0);
        resetn = 1'b1;
        cyc();

        // Short event: rule 2, short time 13; exact cycle latency.
        push(32'h0000_0234);
        enable   = 1'b1;
        ev_ready = 1'b1;
        #1;
        check("t1_rd",       {31'b0, fifo_rd},  32'd1);
        cyc();
        check("t1_wait_rd",  {31'b0, fifo_rd},  32'd0);
        check("t1_wait_val", {31'b0, ev_valid}, 32'd0);
        cyc();
        check("t1_valid", {31'b0, ev_valid}, 32'd1);
        check("t1_rule",  {24'b0, ev_rule},  32'd2);
        check("t1_time",  ev_time,           32'd13);
        check("t1_long",  {31'b0, ev_long},  32'd0);
        cyc();
        check("t1_clear", {31'b0, ev_valid},    32'd0);
        check("t1_evcnt", {16'b0, event_count}, 32'd1);

        // Long event, then a short one with a cleared accumulator.
        push(32'h0000_0FA1);
        push(32'h0000_1114);
        push(32'h0000_221C);
        expect_event("t2a", 8'h11, 32'd1005, 1'b1);
        expect_event("t2b", 8'h22, 32'd7,    1'b0);
        cyc();
        check("t2_evcnt", {16'b0, event_count}, 32'd3);

        // Backpressure: event held, no reads while stalled.
        ev_ready = 1'b0;
        push(32'h0000_3324);
        push(32'h0000_4400);
        expect_event("t3a", 8'h33, 32'd9, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("t3_hold_val",  {31'b0, ev_valid}, 32'd1);
            check("t3_hold_time", ev_time,           32'd9);
            check("t3_hold_rule", {24'b0, ev_rule},  32'h33);
            check("t3_no_rd",     {31'b0, fifo_rd},  32'd0);
        end
        check("t3_cnt_stall", {16'b0, event_count}, 32'd3);
        ev_ready = 1'b1;
        cyc();
        check("t3_evcnt", {16'b0, event_count}, 32'd4);
        check("t3_clear", {31'b0, ev_valid},    32'd0);
        expect_event("t3b", 8'h44, 32'd0, 1'b0);
        cyc();
        check("t3b_evcnt", {16'b0, event_count}, 32'd5);

        // STAT, reserved, then DATA.
        push(32'h0000_0002);
        push(32'h0000_0003);
        push(32'h0000_5504);
        expect_event("t4", 8'h55, 32'd1, 1'b0);
        cyc();
        check("t4_stcnt", {16'b0, stat_count},  32'd1);
        check("t4_err",   {31'b0, err_bad_cmd}, 32'd1);
        check("t4_evcnt", {16'b0, event_count}, 32'd6);

        // Flush during WAIT of the DATA entry that follows TIME=500.
        enable = 1'b0;
        push(32'h0000_07D1);
        push(32'h0000_6628);
        push(32'h0000_770C);
        cyc();
        enable = 1'b1;
        cyc();
        cyc();
        check("t5_rd2",    {31'b0, fifo_rd}, 32'd1);
        cyc();
        check("t5_wait_rd", {31'b0, fifo_rd}, 32'd0);
        flush = 1'b1;
        #1;
        check("t5_flush_rd", {31'b0, fifo_rd}, 32'd0);
        cyc();
        flush = 1'b0;
        check("t5_flush_val", {31'b0, ev_valid}, 32'd0);
        expect_event("t5", 8'h77, 32'd3, 1'b0);
        cyc();
        check("t5_evcnt", {16'b0, event_count}, 32'd7);
        check("t5_stcnt", {16'b0, stat_count},  32'd1);
        check("t5_err",   {31'b0, err_bad_cmd}, 32'd1);

        // Asynchronous reset while an event is held in OUT.
        ev_ready = 1'b0;
        push(32'h0000_8808);
        expect_event("t6", 8'h88, 32'd2, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_arst_val",   {31'b0, ev_valid},    32'd0);
        check("t6_arst_time",  ev_time,              32'd0);
        check("t6_arst_evcnt", {16'b0, event_count}, 32'd0);
        check("t6_arst_stcnt", {16'b0, stat_count},  32'd0);
        check("t6_arst_err",   {31'b0, err_bad_cmd}, 32'd0);
        cyc();
        resetn = 1'b1;

        // Accumulator wrap: 0x3FFFFFFF + 63.
        ev_ready = 1'b1;
        push(32'hFFFF_FFFD);
        push(32'h0000_99FC);
        expect_event("t7", 8'h99, 32'h4000_003E, 1'b1);
        cyc();
        check("t7_evcnt", {16'b0, event_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
